// File: rtl/braille_pkg.sv
// -----------------------------------------------------------------------------
// braille_pkg
// Shared definitions for the Braille quiz controller:
//   - FSM state encoding (3-bit constants)
//   - default symbol count (letters A..J)
//   - packed A..J six-dot pattern table, bit0 = dot1 .. bit5 = dot6
// No ports; imported by braille_rom and braille_quiz_ctrl.
// -----------------------------------------------------------------------------
package braille_pkg;

    typedef logic [5:0] dots_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_JUDGE  = 3'd3;
    localparam logic [2:0] ST_RESULT = 3'd4;

    localparam int NUM_SYMBOLS_DEF = 10;
    localparam int ROM_DEPTH       = 10;

    // Entry k lives at bits [6k +: 6]; letter A is the least significant entry.
    localparam logic [6*ROM_DEPTH-1:0] DOT_TABLE = {
        6'h1A,  // J
        6'h0A,  // I
        6'h13,  // H
        6'h1B,  // G
        6'h0B,  // F
        6'h11,  // E
        6'h19,  // D
        6'h09,  // C
        6'h03,  // B
        6'h01   // A
    };

endpackage

// File: rtl/braille_rom.sv
// -----------------------------------------------------------------------------
// braille_rom
// Combinational symbol-index to dot-pattern lookup.
// Ports:
//   idx   in   4   symbol index, 0 = A
//   dots  out  6   dot pattern; indices past the table give 6'h00
// -----------------------------------------------------------------------------
module braille_rom
    import braille_pkg::*;
(
    input  logic [3:0] idx,
    output dots_t      dots
);

    dots_t entry [0:15];

    // All 16 index values get an entry so the read never leaves the array.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_entry
            if (gi < ROM_DEPTH) begin : g_used
                assign entry[gi] = DOT_TABLE[gi*6 +: 6];
            end else begin : g_empty
                assign entry[gi] = 6'h00;
            end
        end
    endgenerate

    assign dots = entry[idx];

endmodule

// File: rtl/braille_quiz_ctrl.sv
// -----------------------------------------------------------------------------
// braille_quiz_ctrl
// Runs one Braille quiz round: draws an in-range symbol from the LFSR stream,
// presents its dot pattern, waits for the trainee entry, judges it and keeps a
// saturating score / attempt count.
// Optional feature macro: BRAILLE_TIMEOUT_EN (entry window of TIMEOUT_CYCLES
// clocks; without it WAIT_ENTRY waits forever and Timed_Out stays 0).
// Ports:
//   Clk           in   1        system clock, rising edge
//   Rst           in   1        asynchronous active-low reset
//   Rand_In       in   4        LFSR output
//   Start         in   1        request a new round
//   Dots_In       in   6        trainee entry, bit0 = dot1
//   Submit        in   1        entry valid this cycle
//   Clr_Score     in   1        synchronous clear of Score/Attempts
//   Target_Idx    out  4        current symbol index (0 = A)
//   Target_Dots   out  6        dot pattern of Target_Idx
//   Busy          out  1        round in progress (SAMPLE/WAIT_ENTRY/JUDGE)
//   Result_Valid  out  1        one-cycle strobe, Correct/Timed_Out valid
//   Correct       out  1        last judged entry matched
//   Timed_Out     out  1        last round ended by timeout
//   Score         out  SCORE_W  correct answers, saturating
//   Attempts      out  SCORE_W  judged rounds, saturating
// -----------------------------------------------------------------------------
module braille_quiz_ctrl
    import braille_pkg::*;
#(
    parameter int NUM_SYMBOLS = NUM_SYMBOLS_DEF,
    parameter int SCORE_W     = 8
`ifdef BRAILLE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000
`endif
)
(
    input  logic               Clk,
    input  logic               Rst,
    input  logic [3:0]         Rand_In,
    input  logic               Start,
    input  logic [5:0]         Dots_In,
    input  logic               Submit,
    input  logic               Clr_Score,
    output logic [3:0]         Target_Idx,
    output logic [5:0]         Target_Dots,
    output logic               Busy,
    output logic               Result_Valid,
    output logic               Correct,
    output logic               Timed_Out,
    output logic [SCORE_W-1:0] Score,
    output logic [SCORE_W-1:0] Attempts
);

    localparam logic [3:0]         SYM_MAX = 4'(NUM_SYMBOLS);
    localparam logic [SCORE_W-1:0] SAT_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] ONE     = SCORE_W'(1);

    logic [2:0]         state_reg, state_next;
    logic [3:0]         target_idx_reg;
    dots_t              target_dots_reg;
    dots_t              entry_reg;
    logic               result_valid_reg;
    logic               correct_reg;
    logic               timed_out_reg;
    logic [SCORE_W-1:0] score_reg;
    logic [SCORE_W-1:0] attempts_reg;

    logic [3:0] rand_idx;
    dots_t      rom_dots;
    logic       rand_ok;
    logic       timeout_hit;
    logic       judged_correct;

    // Rand_In = k selects symbol k-1; 0 and values past the symbol count are redrawn.
    assign rand_ok  = (Rand_In != 4'd0) && (Rand_In <= SYM_MAX);
    assign rand_idx = Rand_In - 4'd1;

    braille_rom u_rom (
        .idx  (rand_idx),
        .dots (rom_dots)
    );

`ifdef BRAILLE_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             tmo_hit_reg;
    logic             tmo_expire;

    // Expiry only when the counter is spent and the trainee did not submit in that cycle.
    assign tmo_expire  = (state_reg == ST_WAIT) && !Submit && (tmo_cnt_reg == '0);
    assign timeout_hit = tmo_hit_reg;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tmo_cnt_reg <= '0;
            tmo_hit_reg <= 1'b0;
        end else if (state_reg == ST_SAMPLE && rand_ok) begin
            tmo_cnt_reg <= TMO_LOAD;
            tmo_hit_reg <= 1'b0;
        end else if (state_reg == ST_WAIT) begin
            if (Submit) begin
                tmo_hit_reg <= 1'b0;
            end else if (tmo_expire) begin
                tmo_hit_reg <= 1'b1;
            end else begin
                tmo_cnt_reg <= tmo_cnt_reg - TMO_W'(1);
            end
        end
    end
`else
    logic tmo_expire;

    assign tmo_expire  = 1'b0;
    assign timeout_hit = 1'b0;
`endif

    assign judged_correct = !timeout_hit && (entry_reg == target_dots_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (Start) state_next = ST_SAMPLE;
            ST_SAMPLE: if (rand_ok) state_next = ST_WAIT;
            ST_WAIT:   if (Submit || tmo_expire) state_next = ST_JUDGE;
            ST_JUDGE:  state_next = ST_RESULT;
            ST_RESULT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg        <= ST_IDLE;
            target_idx_reg   <= 4'd0;
            target_dots_reg  <= 6'h00;
            entry_reg        <= 6'h00;
            result_valid_reg <= 1'b0;
            correct_reg      <= 1'b0;
            timed_out_reg    <= 1'b0;
            score_reg        <= '0;
            attempts_reg     <= '0;
        end else begin
            state_reg <= state_next;

            // The strobe is registered off RESULT, so it lands two edges after
            // the edge that captured Submit.
            result_valid_reg <= (state_reg == ST_RESULT);

            if (state_reg == ST_SAMPLE && rand_ok) begin
                target_idx_reg  <= rand_idx;
                target_dots_reg <= rom_dots;
            end

            if (state_reg == ST_WAIT && Submit) begin
                entry_reg <= Dots_In;
            end

            if (state_reg == ST_JUDGE) begin
                correct_reg   <= judged_correct;
                timed_out_reg <= timeout_hit;
            end

            // A clear overrides any increment landing on the same edge.
            if (Clr_Score) begin
                score_reg    <= '0;
                attempts_reg <= '0;
            end else if (state_reg == ST_JUDGE) begin
                if (attempts_reg != SAT_MAX) begin
                    attempts_reg <= attempts_reg + ONE;
                end
                if (judged_correct && score_reg != SAT_MAX) begin
                    score_reg <= score_reg + ONE;
                end
            end
        end
    end

    assign Target_Idx   = target_idx_reg;
    assign Target_Dots  = target_dots_reg;
    assign Busy         = (state_reg == ST_SAMPLE) || (state_reg == ST_WAIT) ||
                          (state_reg == ST_JUDGE);
    assign Result_Valid = result_valid_reg;
    assign Correct      = correct_reg;
    assign Timed_Out    = timed_out_reg;
    assign Score        = score_reg;
    assign Attempts     = attempts_reg;

endmodule

// File: tb/tb_braille_quiz_ctrl.sv
// -----------------------------------------------------------------------------
// tb_braille_quiz_ctrl
// Directed bench for braille_quiz_ctrl. Inputs change 1 ns after a rising
// edge; outputs are checked at that same point. With BRAILLE_TIMEOUT_EN the
// entry window is shortened to 8 clocks and the timeout rounds are exercised.
// -----------------------------------------------------------------------------
module tb_braille_quiz_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [3:0] Rand_In = 4'd0;
    logic       Start = 1'b0;
    logic [5:0] Dots_In = 6'h00;
    logic       Submit = 1'b0;
    logic       Clr_Score = 1'b0;
    logic [3:0] Target_Idx;
    logic [5:0] Target_Dots;
    logic       Busy;
    logic       Result_Valid;
    logic       Correct;
    logic       Timed_Out;
    logic [7:0] Score;
    logic [7:0] Attempts;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    braille_quiz_ctrl #(
        .NUM_SYMBOLS    (10),
        .SCORE_W        (8)
`ifdef BRAILLE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Rand_In      (Rand_In),
        .Start        (Start),
        .Dots_In      (Dots_In),
        .Submit       (Submit),
        .Clr_Score    (Clr_Score),
        .Target_Idx   (Target_Idx),
        .Target_Dots  (Target_Dots),
        .Busy         (Busy),
        .Result_Valid (Result_Valid),
        .Correct      (Correct),
        .Timed_Out    (Timed_Out),
        .Score        (Score),
        .Attempts     (Attempts)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full round with an in-range draw; ends right after the Result_Valid edge.
    task automatic run_round(input logic [3:0] r, input logic [5:0] d, input logic clr_in_judge);
        Start = 1'b1; Rand_In = r;
        tick();                       // IDLE -> SAMPLE
        Start = 1'b0;
        tick();                       // accept -> WAIT_ENTRY
        Dots_In = d; Submit = 1'b1;
        tick();                       // -> JUDGE
        Submit = 1'b0; Clr_Score = clr_in_judge;
        tick();                       // JUDGE -> RESULT
        Clr_Score = 1'b0;
        tick();                       // RESULT -> IDLE, strobe high
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", Busy, 0);
        chk("rst_rv", Result_Valid, 0);
        chk("rst_idx", Target_Idx, 0);
        chk("rst_dots", Target_Dots, 0);
        chk("rst_score", Score, 0);
        chk("rst_att", Attempts, 0);
        chk("rst_correct", Correct, 0);
        chk("rst_to", Timed_Out, 0);
        Rst = 1'b1;
        tick();
        $display("reset released");

        // 1: Start with Rand_In=3 -> C after one SAMPLE cycle
        Start = 1'b1; Rand_In = 4'd3;
        tick();
        Start = 1'b0;
        chk("t1_busy_sample", Busy, 1);
        tick();
        chk("t1_idx", Target_Idx, 2);
        chk("t1_dots", Target_Dots, 6'h09);
        chk("t1_busy_wait", Busy, 1);
        $display("round 1 target idx=%0d dots=%h", Target_Idx, Target_Dots);

        // 2: correct entry, strobe two edges after the Submit edge
        Dots_In = 6'h09; Submit = 1'b1;
        tick();                       // edge N
        Submit = 1'b0;
        chk("t2_rv_n", Result_Valid, 0);
        tick();                       // edge N+1
        chk("t2_rv_n1", Result_Valid, 0);
        chk("t2_busy_result", Busy, 0);
        tick();                       // edge N+2
        chk("t2_rv_n2", Result_Valid, 1);
        chk("t2_correct", Correct, 1);
        chk("t2_score", Score, 1);
        chk("t2_att", Attempts, 1);
        tick();
        chk("t2_rv_drop", Result_Valid, 0);
        chk("t2_idx_hold", Target_Idx, 2);
        $display("round 2 correct=%0d score=%0d attempts=%0d", Correct, Score, Attempts);

        // 3: draws 0,12,15 rejected, 5 accepted -> E; wrong entry
        Start = 1'b1; Rand_In = 4'd0;
        tick();
        Start = 1'b0;
        tick();
        chk("t3_rej0_busy", Busy, 1);
        chk("t3_rej0_idx", Target_Idx, 2);
        Rand_In = 4'd12;
        tick();
        Rand_In = 4'd15;
        tick();
        chk("t3_rej15_idx", Target_Idx, 2);
        Rand_In = 4'd5;
        tick();
        chk("t3_idx", Target_Idx, 4);
        chk("t3_dots", Target_Dots, 6'h11);
        Dots_In = 6'h01; Submit = 1'b1;
        tick();
        Submit = 1'b0;
        tick();
        tick();
        chk("t3_rv", Result_Valid, 1);
        chk("t3_correct", Correct, 0);
        chk("t3_score", Score, 1);
        chk("t3_att", Attempts, 2);
        $display("round 3 target idx=%0d correct=%0d attempts=%0d", Target_Idx, Correct, Attempts);

`ifdef BRAILLE_TIMEOUT_EN
        // 5: no Submit -> timeout after 8 WAIT_ENTRY cycles
        Start = 1'b1; Rand_In = 4'd2;
        tick();
        Start = 1'b0;
        tick();                       // accept B, counter loaded
        chk("t5_idx", Target_Idx, 1);
        Dots_In = 6'h03;              // matches B but never submitted
        for (int i = 0; i < 8; i++) tick();
        chk("t5_busy_judge", Busy, 1);
        chk("t5_to_before", Timed_Out, 0);
        tick();
        chk("t5_to", Timed_Out, 1);
        chk("t5_correct", Correct, 0);
        chk("t5_att", Attempts, 3);
        chk("t5_score", Score, 1);
        tick();
        chk("t5_rv", Result_Valid, 1);
        $display("timeout round timed_out=%0d attempts=%0d", Timed_Out, Attempts);

        // 5b: Submit on the expiry cycle wins
        Start = 1'b1; Rand_In = 4'd2;
        tick();
        Start = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        Submit = 1'b1; Dots_In = 6'h03;
        tick();                       // expiry edge with Submit
        Submit = 1'b0;
        tick();
        chk("t5b_to", Timed_Out, 0);
        chk("t5b_correct", Correct, 1);
        chk("t5b_att", Attempts, 4);
        chk("t5b_score", Score, 2);
        tick();
        $display("expiry-submit round timed_out=%0d correct=%0d", Timed_Out, Correct);
`endif

        // 4: clear, saturate, hold at max, clear during JUDGE
        Clr_Score = 1'b1;
        tick();
        Clr_Score = 1'b0;
        chk("t4_clr_score", Score, 0);
        chk("t4_clr_att", Attempts, 0);
        chk("t4_clr_idle", Busy, 0);
        for (int i = 0; i < 255; i++) run_round(4'd1, 6'h01, 1'b0);
        chk("t4_full_score", Score, 8'hFF);
        chk("t4_full_att", Attempts, 8'hFF);
        run_round(4'd1, 6'h01, 1'b0);
        chk("t4_sat_score", Score, 8'hFF);
        chk("t4_sat_att", Attempts, 8'hFF);
        chk("t4_sat_rv", Result_Valid, 1);
        run_round(4'd8, 6'h13, 1'b1);
        chk("t4_jclr_score", Score, 0);
        chk("t4_jclr_att", Attempts, 0);
        chk("t4_jclr_rv", Result_Valid, 1);
        chk("t4_jclr_correct", Correct, 1);
        chk("t4_jclr_dots", Target_Dots, 6'h13);
        $display("saturation/clear score=%0d attempts=%0d", Score, Attempts);
        tick();

        // 6: reset while waiting for entry
        Start = 1'b1; Rand_In = 4'd7;
        tick();
        Start = 1'b0;
        tick();
        chk("t6_idx", Target_Idx, 6);
        chk("t6_dots", Target_Dots, 6'h1B);
        Dots_In = 6'h1B; Submit = 1'b1;
        #2;
        Rst = 1'b0;
        #1;
        Submit = 1'b0;
        chk("t6_async_busy", Busy, 0);
        chk("t6_async_idx", Target_Idx, 0);
        chk("t6_async_dots", Target_Dots, 0);
        chk("t6_async_correct", Correct, 0);
        tick();
        tick();
        chk("t6_no_rv", Result_Valid, 0);
        chk("t6_att", Attempts, 0);
        Rst = 1'b1;
        tick();
        chk("t6_idle_rv", Result_Valid, 0);
        run_round(4'd10, 6'h1A, 1'b0);
        chk("t6_clean_idx", Target_Idx, 9);
        chk("t6_clean_rv", Result_Valid, 1);
        chk("t6_clean_correct", Correct, 1);
        chk("t6_clean_score", Score, 1);
        chk("t6_clean_att", Attempts, 1);
        $display("post-reset round idx=%0d correct=%0d score=%0d", Target_Idx, Correct, Score);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
